quad_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 36 +++
 rtl/quad_filter.sv | 58 +++++
 rtl/quad_decoder.sv | 96 +++++++++
 tb/tb_quad_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared Gray-code state encodings and the step classifier used by the quadrature decoder.
package quad_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  // Position of a {A,B} state along the up sequence 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] s);
    logic [1:0] idx;
    case (s)
      S00:     idx = 2'd0;
      S01:     idx = 2'd1;
      S11:     idx = 2'd2;
      S10:     idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Returns {valid, up, illegal}; a two-position jump means both pins moved at once.
  function automatic logic [2:0] step_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    logic [2:0] r;
    d = gray_idx(cur) - gray_idx(prev);
    case (d)
      2'd1:    r = 3'b110;
      2'd3:    r = 3'b100;
      2'd2:    r = 3'b001;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: 2-FF synchroniser followed by a FILT_LEN-sample stability filter.
module quad_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_valid
);

  localparam int CNT_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_LEN - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  // Metastability synchroniser, deliberately without reset.
  always_ff @(posedge clk) begin
    r_sync1 <= i_pin;
    r_sync2 <= r_sync1;
  end

  // Before the first acceptance r_level acts as the candidate; afterwards a level must differ for FILT_LEN samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_valid <= 1'b0;
    end else if (!r_valid) begin
      if (r_sync2 != r_level) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (r_cnt == LAST) begin
        r_valid <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_valid = r_valid;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B channels, x4 Gray decode, position/error counters and SPI snapshot.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int POS_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clear,
  input  logic             snap,
  output logic [POS_W-1:0] position,
  output logic [POS_W-1:0] snapshot,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  logic       w_a_level, w_a_valid, w_b_level, w_b_valid;
  logic [1:0] w_cur;
  logic [2:0] w_sd;
  logic       w_valid, w_up, w_illegal;

  logic [1:0]       r_prev;
  logic             r_init;
  logic [POS_W-1:0] r_position;
  logic [POS_W-1:0] r_snapshot;
  logic             r_step, r_dir, r_err;
  logic [ERR_W-1:0] r_err_count;

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .i_pin(quad_a), .o_level(w_a_level), .o_valid(w_a_valid)
  );

  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .i_pin(quad_b), .o_level(w_b_level), .o_valid(w_b_valid)
  );

  assign w_cur     = {w_a_level, w_b_level};
  assign w_sd      = step_dir(r_prev, w_cur);
  assign w_valid   = r_init & w_sd[2];
  assign w_up      = w_sd[1];
  assign w_illegal = r_init & w_sd[0];

  // Decode, counters and snapshot; the init cycle only captures the pin state so power-up levels never count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= S00;
      r_init      <= 1'b0;
      r_position  <= '0;
      r_snapshot  <= '0;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_step <= w_valid;
      r_err  <= w_illegal;
      if (snap) begin
        r_snapshot <= r_position;
      end
      if (!r_init) begin
        if (w_a_valid && w_b_valid) begin
          r_prev <= w_cur;
          r_init <= 1'b1;
        end
      end else begin
        r_prev <= w_cur;
      end
      if (w_valid) begin
        r_dir <= w_up;
      end
      if (w_illegal && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
      // clear wins over a same-cycle step; the step pulse still fires.
      if (clear) begin
        r_position <= '0;
      end else if (w_valid) begin
        r_position <= w_up ? r_position + POS_W'(1) : r_position - POS_W'(1);
      end
    end
  end

  assign position  = r_position;
  assign snapshot  = r_snapshot;
  assign step      = r_step;
  assign dir       = r_dir;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: scoreboard of expected steps plus per-feature scenario tasks.
module tb_quad_decoder;

  logic        clk = 1'b0;
  logic        rst, quad_a, quad_b, clear, snap;
  logic [15:0] position, snapshot;
  logic        step, dir, err;
  logic [7:0]  err_count;

  typedef struct {
    logic [15:0] pos;
    logic        dir;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          step_seen = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  logic [15:0] model_pos;
  logic [1:0]  cur_ab;

  quad_decoder #(.POS_W(16), .FILT_LEN(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .clear(clear), .snap(snap),
    .position(position), .snapshot(snapshot), .step(step), .dir(dir), .err(err),
    .err_count(err_count)
  );

  always #10 clk = ~clk;

  // Scoreboard: every step pulse must match the oldest expected position/direction.
  always @(negedge clk) begin
    if (!rst && step) begin
      step_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: position=%h dir=%b, no step expected", position, dir);
      end else begin
        mon_e = exp_q.pop_front();
        if (position !== mon_e.pos || dir !== mon_e.dir) begin
          errors++;
          $display("FAIL step_value: position=%h dir=%b, expected position=%h dir=%b",
                   position, dir, mon_e.pos, mon_e.dir);
        end
      end
    end
    if (!rst && err) err_seen++;
  end

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic move(input logic [1:0] ns, input int hold);
    int d;
    d = (gidx(ns) - gidx(cur_ab) + 4) % 4;
    if (d == 1) begin
      model_pos = model_pos + 16'd1;
      exp_q.push_back('{pos: model_pos, dir: 1'b1});
    end else if (d == 3) begin
      model_pos = model_pos - 16'd1;
      exp_q.push_back('{pos: model_pos, dir: 1'b0});
    end else if (d == 2) begin
      exp_err++;
    end
    cur_ab = ns;
    quad_a = ns[1];
    quad_b = ns[0];
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst = 1'b1; quad_a = a; quad_b = b; clear = 1'b0; snap = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_pos = 16'd0;
    cur_ab = {a, b};
    exp_err = 0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d steps still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    int s0;
    do_reset(1'b1, 1'b1);
    s0 = step_seen;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (position !== 16'd0 || snapshot !== 16'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: pos=%h snap=%h errc=%h, required 0", position, snapshot, err_count);
    end
    checks++;
    if (step_seen != s0 || dir !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_step: steps=%0d dir=%b err=%b, required 0", step_seen - s0, dir, err);
    end
    checks++;
    if (dut.r_init !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: init=%b, required 1", dut.r_init);
    end
  endtask

  task automatic test_forward;
    logic [1:0] seq [4];
    int s0;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    s0 = step_seen;
    move(seq[0], 0);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e <= 7) begin
        checks++;
        if (step !== (e == 7)) begin
          errors++;
          $display("FAIL latency_edge%0d: step=%b, required %b", e, step, (e == 7));
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) move(seq[i % 4], 10);
    checks++;
    if (position !== 16'd8 || dir !== 1'b1 || step_seen - s0 != 8) begin
      errors++;
      $display("FAIL forward: pos=%h dir=%b steps=%0d, required 0008 1 8", position, dir, step_seen - s0);
    end
    check_drained("forward");
  endtask

  task automatic test_wrap;
    do_reset(1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    force dut.r_position = 16'h7FFF;
    @(posedge clk);
    #1;
    release dut.r_position;
    model_pos = 16'h7FFF;
    move(2'b01, 10);
    checks++;
    if (position !== 16'h8000) begin
      errors++;
      $display("FAIL wrap_up: pos=%h, required 8000", position);
    end
    move(2'b00, 10);
    checks++;
    if (position !== 16'h7FFF || dir !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down: pos=%h dir=%b, required 7fff 0", position, dir);
    end
    check_drained("wrap");
  endtask

  task automatic test_glitch_illegal;
    int s0, e0;
    do_reset(1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    s0 = step_seen;
    e0 = err_seen;
    quad_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    quad_a = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (step_seen != s0 || err_seen != e0 || position !== 16'd0) begin
      errors++;
      $display("FAIL glitch: steps=%0d errs=%0d pos=%h, required 0 0 0000", step_seen - s0, err_seen - e0, position);
    end
    move(2'b11, 12);
    checks++;
    if (err_seen - e0 != exp_err || err_count !== 8'd1 || position !== 16'd0) begin
      errors++;
      $display("FAIL illegal: errs=%0d errc=%0d pos=%h, required %0d 1 0000", err_seen - e0, err_count, position, exp_err);
    end
    check_drained("glitch");
  endtask

  task automatic test_snapshot;
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    snap = 1'b1;
    for (int i = 0; i < 5; i++) move(seq[i % 4], 10);
    snap = 1'b0;
    for (int i = 5; i < 8; i++) move(seq[i % 4], 10);
    checks++;
    if (snapshot !== 16'd5 || position !== 16'd8) begin
      errors++;
      $display("FAIL snap_hold: snap=%h pos=%h, required 0005 0008", snapshot, position);
    end
    clear = 1'b1;
    snap = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    snap = 1'b0;
    model_pos = 16'd0;
    checks++;
    if (snapshot !== 16'd8 || position !== 16'd0) begin
      errors++;
      $display("FAIL snap_clear: snap=%h pos=%h, required 0008 0000", snapshot, position);
    end
    check_drained("snapshot");
  endtask

  task automatic test_saturate;
    int e0;
    do_reset(1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    e0 = err_seen;
    for (int i = 0; i < 300; i++) move((i % 2 == 0) ? 2'b11 : 2'b00, 8);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'd255 || err_seen - e0 != exp_err) begin
      errors++;
      $display("FAIL saturate: errc=%0d pulses=%0d, required 255 %0d", err_count, err_seen - e0, exp_err);
    end
    checks++;
    if (position !== 16'd0) begin
      errors++;
      $display("FAIL saturate_pos: pos=%h, required 0000", position);
    end
  endtask

  initial begin
    rst = 1'b1; quad_a = 1'b0; quad_b = 1'b0; clear = 1'b0; snap = 1'b0;
    model_pos = 16'd0;
    cur_ab = 2'b00;
    test_reset();
    test_forward();
    test_wrap();
    test_glitch_illegal();
    test_snapshot();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
